// File: rtl/pipe_stage_reg_if.sv
// Valid/ready payload channel between pipeline stages.
// The master drives valid, data and ctrl; the slave returns ready.
interface pipe_stage_reg_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CTRL_W = 11
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;
   logic [CTRL_W-1:0] ctrl;

   modport master (output valid, output data, output ctrl, input ready);
   modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with stall, flush and held-cycle reporting.
// Define SKID_BUF_EN for a 2-entry main+skid buffer that removes the out_ready->in_ready path.
module pipe_stage_reg #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned CTRL_W     = 11,
   parameter bit          CLEAR_DATA = 1'b1,
   parameter int unsigned CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_stall,
   input  logic             i_flush,
   pipe_stage_reg_if.slave  i_up,
   pipe_stage_reg_if.master o_dn,
   output logic             o_held,
   output logic [CNT_W-1:0] o_hold_cnt
);

   logic              w_in_ready;
   logic              w_in_fire;
   logic              w_out_fire;
   logic              w_held_d;

   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic [CTRL_W-1:0] r_ctrl;
   logic              w_valid_d;
   logic [DATA_W-1:0] w_data_d;
   logic [CTRL_W-1:0] w_ctrl_d;

   logic              r_held;
   logic [CNT_W-1:0]  r_hold_cnt;

`ifdef SKID_BUF_EN
   logic              r_skid_valid;
   logic [DATA_W-1:0] r_skid_data;
   logic [CTRL_W-1:0] r_skid_ctrl;
   logic              w_skid_valid_d;
   logic [DATA_W-1:0] w_skid_data_d;
   logic [CTRL_W-1:0] w_skid_ctrl_d;

   // Ready depends only on local state, so no combinational path from downstream.
   assign w_in_ready = ~i_stall & ~r_skid_valid;
`else
   assign w_in_ready = ~i_stall & (~r_valid | o_dn.ready);
`endif

   assign w_in_fire  = i_up.valid & w_in_ready;
   assign w_out_fire = r_valid & o_dn.ready & ~i_stall;
   assign w_held_d   = r_valid & ~w_out_fire;

   always_comb begin
      w_valid_d = r_valid;
      w_data_d  = r_data;
      w_ctrl_d  = r_ctrl;
`ifdef SKID_BUF_EN
      w_skid_valid_d = r_skid_valid;
      w_skid_data_d  = r_skid_data;
      w_skid_ctrl_d  = r_skid_ctrl;
      if (w_out_fire) begin
         if (r_skid_valid) begin
            w_data_d       = r_skid_data;
            w_ctrl_d       = r_skid_ctrl;
            w_skid_valid_d = 1'b0;
            if (w_in_fire) begin
               w_skid_valid_d = 1'b1;
               w_skid_data_d  = i_up.data;
               w_skid_ctrl_d  = i_up.ctrl;
            end
         end else if (w_in_fire) begin
            w_data_d = i_up.data;
            w_ctrl_d = i_up.ctrl;
         end else begin
            w_valid_d = 1'b0;
         end
      end else if (w_in_fire) begin
         // Main still occupied: park the new payload behind it.
         if (r_valid) begin
            w_skid_valid_d = 1'b1;
            w_skid_data_d  = i_up.data;
            w_skid_ctrl_d  = i_up.ctrl;
         end else begin
            w_valid_d = 1'b1;
            w_data_d  = i_up.data;
            w_ctrl_d  = i_up.ctrl;
         end
      end
`else
      if (w_in_fire) begin
         w_valid_d = 1'b1;
         w_data_d  = i_up.data;
         w_ctrl_d  = i_up.ctrl;
      end else if (w_out_fire) begin
         w_valid_d = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_ctrl  <= '0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
         r_ctrl  <= '0;
         if (CLEAR_DATA) begin
            r_data <= '0;
         end
      end else begin
         r_valid <= w_valid_d;
         r_data  <= w_data_d;
         r_ctrl  <= w_ctrl_d;
      end
   end

`ifdef SKID_BUF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_skid_valid <= 1'b0;
         r_skid_data  <= '0;
         r_skid_ctrl  <= '0;
      end else if (i_flush) begin
         r_skid_valid <= 1'b0;
      end else begin
         r_skid_valid <= w_skid_valid_d;
         r_skid_data  <= w_skid_data_d;
         r_skid_ctrl  <= w_skid_ctrl_d;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_held     <= 1'b0;
         r_hold_cnt <= '0;
      end else if (i_flush) begin
         r_held     <= 1'b0;
         r_hold_cnt <= '0;
      end else begin
         r_held <= w_held_d;
         if (!w_held_d) begin
            r_hold_cnt <= '0;
         end else if (r_hold_cnt != {CNT_W{1'b1}}) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
         end
      end
   end

   assign i_up.ready = w_in_ready;
   assign o_dn.valid = r_valid;
   assign o_dn.data  = r_data;
   assign o_dn.ctrl  = r_ctrl;
   assign o_held     = r_held;
   assign o_hold_cnt = r_hold_cnt;

endmodule
